// File: rtl/i2c_byte_engine_if.sv
// Host-side handshake between the Wishbone register block and the I2C byte engine.
interface i2c_byte_engine_if;
  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;

  modport master (
    output start, rw, dev_addr, wr_data,
    input  busy, done, ack_err, rd_data
  );

  modport slave (
    input  start, rw, dev_addr, wr_data,
    output busy, done, ack_err, rd_data
  );
endinterface

// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master sequencer: START, address + R/W, one data byte, ACK checks, STOP.
// Every SDA action is paced by the SCL generator's mid/end phase strobes.
module i2c_byte_engine #(
  parameter int unsigned START_HOLD = 20000,
  parameter int unsigned STOP_HOLD  = 20000
) (
  input  logic            clk,
  input  logic            rst,
  i2c_byte_engine_if.slave host,
  input  logic            mid_low,
  input  logic            end_low,
  input  logic            mid_high,
  input  logic            end_high,
  output logic            sclk_en,
  output logic            stop_cond,
  inout  wire             i2c_sdat
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA,
    S_DATA_ACK, S_STOP_LOW, S_STOP_WAIT, S_STOP_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        sda_low_q, sda_low_d;
  logic        sclk_en_q, sclk_en_d;
  logic        stop_q, stop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rd_q, rd_d;
  logic        sda_in;

  // Open drain: only ever pull low or release.
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in   = i2c_sdat;

  assign sclk_en      = sclk_en_q;
  assign stop_cond    = stop_q;
  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.ack_err = ack_err_q;
  assign host.rd_data = rd_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      sda_low_q <= 1'b0;
      sclk_en_q <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      sda_low_q <= sda_low_d;
      sclk_en_q <= sclk_en_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_q      <= rd_d;
    end
  end

  // Next-state and output decode; strobes are only acted on in bit-level states.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    sda_low_d = sda_low_q;
    sclk_en_d = sclk_en_q;
    stop_d    = stop_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_d      = rd_q;
    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          shift_d   = {host.dev_addr, host.rw};
          rw_d      = host.rw;
          wdata_d   = host.wr_data;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          sda_low_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == START_HOLD - 1) begin
          sclk_en_d = 1'b1;
          bit_d     = 3'd7;
          cnt_d     = '0;
          state_d   = S_ADDR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ADDR: begin
        if (mid_low) sda_low_d = ~shift_q[bit_q];
        if (end_high) begin
          if (bit_q == 3'd0) state_d = S_ADDR_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_ADDR_ACK: begin
        if (mid_low) sda_low_d = 1'b0;
        if (mid_high && sda_in) ack_err_d = 1'b1;
        if (end_high) begin
          if (ack_err_q) begin
            state_d = S_STOP_LOW;
          end else begin
            // The write byte reuses the address shifter from here on.
            shift_d = wdata_q;
            bit_d   = 3'd7;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rw_q) begin
          if (mid_low)  sda_low_d = 1'b0;
          if (mid_high) rd_d = {rd_q[6:0], sda_in};
        end else if (mid_low) begin
          sda_low_d = ~shift_q[bit_q];
        end
        if (end_high) begin
          if (bit_q == 3'd0) state_d = S_DATA_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_DATA_ACK: begin
        if (mid_low) sda_low_d = 1'b0;
        if (!rw_q && mid_high && sda_in) ack_err_d = 1'b1;
        if (end_high) state_d = S_STOP_LOW;
      end
      S_STOP_LOW: begin
        if (mid_low) begin
          sda_low_d = 1'b1;
          state_d   = S_STOP_WAIT;
        end
      end
      S_STOP_WAIT: begin
        if (end_low) begin
          sclk_en_d = 1'b0;
          stop_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_STOP_HOLD;
        end
      end
      S_STOP_HOLD: begin
        if (cnt_q == STOP_HOLD - 1) begin
          sda_low_d = 1'b0;
          stop_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine with a behavioural SCL generator and I2C slave.
module tb_i2c_byte_engine;
  localparam int START_H = 5;
  localparam int STOP_H  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mid_low = 1'b0, end_low = 1'b0, mid_high = 1'b0, end_high = 1'b0;
  logic sclk_en, stop_cond;
  wire  sda;
  logic slv_low = 1'b0;

  i2c_byte_engine_if bus ();

  i2c_byte_engine #(.START_HOLD(START_H), .STOP_HOLD(STOP_H)) dut (
    .clk(clk), .rst(rst), .host(bus),
    .mid_low(mid_low), .end_low(end_low), .mid_high(mid_high), .end_high(end_high),
    .sclk_en(sclk_en), .stop_cond(stop_cond), .i2c_sdat(sda)
  );

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave configuration (written by the test tasks only)
  logic       slv_ack_a = 1'b1, slv_ack_d = 1'b1, slv_read = 1'b0;
  logic [7:0] slv_rbyte = 8'h00;

  // generator state (written by the generator only)
  int   nper = 0, nfull = 0;
  logic cap [0:31];

  // monitor state (written by the monitor only)
  int   cyc = 0, done_cnt = 0, overlap = 0, t_stop = 0, t_sda = 0, t_done = 0;
  logic prev_stop = 1'b0, prev_sda = 1'b1;

  // runner results
  logic got_done;
  int   t_en, done_base, ov_base;
  logic busy0, sda0;

  function automatic logic [7:0] cap_byte(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap[5'(s + i)];
    return b;
  endfunction

  task automatic gstep();
    @(posedge clk); #1;
  endtask

  task automatic scl_period();
    gstep(); gstep();
    nper++;
    mid_low = 1'b1;
    if (nper == 9)                              slv_low = slv_ack_a;
    else if (nper >= 10 && nper <= 17 && slv_read) slv_low = ~slv_rbyte[3'(17 - nper)];
    else if (nper == 18 && !slv_read)           slv_low = slv_ack_d;
    else                                        slv_low = 1'b0;
    gstep(); mid_low = 1'b0;
    gstep();
    end_low = 1'b1; gstep(); gstep(); gstep(); end_low = 1'b0;
    if (!sclk_en) return;
    gstep(); mid_high = 1'b1; cap[5'(nper)] = sda;
    gstep(); mid_high = 1'b0;
    gstep(); end_high = 1'b1;
    gstep(); end_high = 1'b0;
    nfull++;
  endtask

  // SCL generator plus slave: runs periods while sclk_en is high, parks when it drops.
  initial begin : scl_gen
    forever begin
      gstep();
      if (sclk_en) begin
        nper = 0; nfull = 0;
        for (int i = 0; i < 32; i++) cap[i] = 1'b1;
        while (sclk_en) scl_period();
      end
    end
  end

  // Bus monitor: done count, STOP edge timing, stop_cond/sclk_en overlap.
  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      if (stop_cond && sclk_en) overlap++;
      if (stop_cond && !prev_stop) t_stop = cyc;
      if (sda && !prev_sda) t_sda = cyc;
      if (bus.done) begin done_cnt++; t_done = cyc; end
      prev_stop = stop_cond;
      prev_sda  = sda;
    end
  end

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic aa, input logic ad, input logic [7:0] rb, input logic poke);
    logic poked;
    poked = 1'b0;
    slv_ack_a = aa; slv_ack_d = ad; slv_read = r; slv_rbyte = rb;
    got_done = 1'b0; t_en = -1;
    done_base = done_cnt; ov_base = overlap;
    @(negedge clk);
    bus.dev_addr = a; bus.rw = r; bus.wr_data = wd; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy0 = bus.busy; sda0 = sda;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      if (sclk_en && t_en < 0) t_en = c;
      if (bus.done) got_done = 1'b1;
      if (poke && !poked && nper == 3 && nfull == 2) begin
        bus.start = 1'b1; bus.dev_addr = 7'h7F; bus.wr_data = 8'h00; bus.rw = ~r;
        poked = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sclk_en !== 1'b0)   begin errors++; $display("FAIL reset_sclk_en: got %b want 0", sclk_en); end
    checks++; if (stop_cond !== 1'b0) begin errors++; $display("FAIL reset_stop_cond: got %b want 0", stop_cond); end
    checks++; if (sda !== 1'b1)       begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0", bus.ack_err); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL wr_timeout: got done=%b want 1", got_done); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL wr_busy_after_start: got %b want 1", busy0); end
    checks++; if (sda0 !== 1'b0)  begin errors++; $display("FAIL wr_start_sda: got %b want 0", sda0); end
    checks++; if (t_en !== START_H) begin errors++; $display("FAIL wr_sclk_en_delay: got %0d want %0d", t_en, START_H); end
    checks++; if (cap_byte(1) !== 8'hA0) begin errors++; $display("FAIL wr_addr_byte: got %h want a0", cap_byte(1)); end
    checks++; if (cap[9] !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", cap[9]); end
    checks++; if (cap_byte(10) !== 8'hA5) begin errors++; $display("FAIL wr_data_byte: got %h want a5", cap_byte(10)); end
    checks++; if (cap[18] !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b want 0", cap[18]); end
    checks++; if (nfull !== 18) begin errors++; $display("FAIL wr_periods: got %0d want 18", nfull); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err: got %b want 0", bus.ack_err); end
    checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL wr_done_pulses: got %0d want 1", done_cnt - done_base); end
    checks++; if (sda !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL wr_idle_after: got sda=%b busy=%b want 1 0", sda, bus.busy); end
    checks++; if (t_sda - t_stop !== STOP_H) begin errors++; $display("FAIL wr_stop_hold: got %0d want %0d", t_sda - t_stop, STOP_H); end
    checks++; if (t_done - t_sda !== 1) begin errors++; $display("FAIL wr_done_after_sda: got %0d want 1", t_done - t_sda); end
    checks++; if (overlap !== ov_base) begin errors++; $display("FAIL wr_stop_overlap: got %0d want %0d", overlap, ov_base); end
  endtask

  task automatic test_read();
    run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL rd_timeout: got done=%b want 1", got_done); end
    checks++; if (cap_byte(1) !== 8'hA1) begin errors++; $display("FAIL rd_addr_byte: got %h want a1", cap_byte(1)); end
    checks++; if (cap_byte(10) !== 8'h3C) begin errors++; $display("FAIL rd_bus_byte: got %h want 3c", cap_byte(10)); end
    checks++; if (cap[18] !== 1'b1) begin errors++; $display("FAIL rd_master_nack: got %b want 1", cap[18]); end
    checks++; if (bus.rd_data !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h want 3c", bus.rd_data); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err: got %b want 0", bus.ack_err); end
    checks++; if (nfull !== 18) begin errors++; $display("FAIL rd_periods: got %0d want 18", nfull); end
    checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL rd_done_pulses: got %0d want 1", done_cnt - done_base); end
  endtask

  task automatic test_addr_nack();
    run_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL an_timeout: got done=%b want 1", got_done); end
    checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL an_ack_err: got %b want 1", bus.ack_err); end
    checks++; if (cap[9] !== 1'b1) begin errors++; $display("FAIL an_ack_bit: got %b want 1", cap[9]); end
    checks++; if (nfull !== 9) begin errors++; $display("FAIL an_periods: got %0d want 9", nfull); end
    checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL an_done_pulses: got %0d want 1", done_cnt - done_base); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL an_sda_end: got %b want 1", sda); end
    checks++; if (t_sda - t_stop !== STOP_H) begin errors++; $display("FAIL an_stop_hold: got %0d want %0d", t_sda - t_stop, STOP_H); end
    checks++; if (overlap !== ov_base) begin errors++; $display("FAIL an_stop_overlap: got %0d want %0d", overlap, ov_base); end
  endtask

  task automatic test_data_nack();
    run_txn(7'h2B, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL dn_timeout: got done=%b want 1", got_done); end
    checks++; if (cap_byte(1) !== 8'h56) begin errors++; $display("FAIL dn_addr_byte: got %h want 56", cap_byte(1)); end
    checks++; if (cap_byte(10) !== 8'h0F) begin errors++; $display("FAIL dn_data_byte: got %h want 0f", cap_byte(10)); end
    checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL dn_ack_err: got %b want 1", bus.ack_err); end
    checks++; if (nfull !== 18) begin errors++; $display("FAIL dn_periods: got %0d want 18", nfull); end
    checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL dn_done_pulses: got %0d want 1", done_cnt - done_base); end
  endtask

  task automatic test_back_to_back_start();
    run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL bb_timeout: got done=%b want 1", got_done); end
    checks++; if (cap_byte(1) !== 8'hA0) begin errors++; $display("FAIL bb_addr_byte: got %h want a0", cap_byte(1)); end
    checks++; if (cap_byte(10) !== 8'hA5) begin errors++; $display("FAIL bb_data_byte: got %h want a5", cap_byte(10)); end
    checks++; if (nfull !== 18) begin errors++; $display("FAIL bb_periods: got %0d want 18", nfull); end
    checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL bb_done_pulses: got %0d want 1", done_cnt - done_base); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bb_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_data();
    logic seen;
    slv_ack_a = 1'b1; slv_ack_d = 1'b1; slv_read = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    bus.dev_addr = 7'h50; bus.rw = 1'b0; bus.wr_data = 8'hA5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (sclk_en && nper == 14 && nfull == 13) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_reach_bit3: got %b want 1", seen); end
    repeat (3) @(negedge clk);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rm_bit3_low: got %b want 0", sda); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sclk_en !== 1'b0) begin errors++; $display("FAIL rm_sclk_en: got %b want 0", sclk_en); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda: got %b want 1", sda); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rm_rd_data: got %h want 00", bus.rd_data); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || sclk_en !== 1'b0 || stop_cond !== 1'b0) begin
      errors++; $display("FAIL rm_stays_idle: got busy=%b sclk_en=%b stop=%b want 0 0 0", bus.busy, sclk_en, stop_cond);
    end
  endtask

  initial begin : main
    bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = '0; bus.wr_data = '0;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_back_to_back_start();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_byte_engine.md
# i2c_byte_engine

Byte-level I2C master sequencer that sits directly upstream of the SCL generator in the wb_i2c path. It issues START, shifts a 7-bit address plus R/W bit and one data byte on SDA, checks ACKs, and issues STOP. It drives the generator's `sclk_en` and `stop_cond` inputs and paces every SDA action from the generator's mid/end phase strobes. It presents a simple start/done handshake toward the Wishbone register block.

## Interface
- `START_HOLD`, 20000: clk cycles SDA is held low with SCL high before `sclk_en` rises (START hold time).
- `STOP_HOLD`, 20000: clk cycles SCL is high with SDA low before SDA is released (STOP setup time).
- `clk`  in  1  system clock, same clock as the SCL generator.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `rw`  in  1  0 = write `wr_data`, 1 = read one byte.
- `dev_addr`  in  7  slave address; latched on an accepted `start`.
- `wr_data`  in  8  write byte; latched on an accepted `start`.
- `mid_low`, `end_low`, `mid_high`, `end_high`  in  1 each  generator phase strobes; `end_low` may stay high for many cycles, the others are 1-cycle pulses.
- `sclk_en`  out  1  generator enable.
- `stop_cond`  out  1  generator stop request.
- `i2c_sdat`  inout  1  open-drain SDA: drives 0 or high-Z, never drives 1.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  NACK seen on the address or write-data byte; valid with `done`, held until the next accepted `start`.
- `rd_data`  out  8  read byte; valid with `done` when `rw`=1, held until overwritten.

## Operation
- Reset values: `sclk_en`=0, `stop_cond`=0, SDA released, `busy`=0, `done`=0, `ack_err`=0, `rd_data`=0x00, state IDLE. Reset mid-transaction returns to these values immediately.
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP_LOW, STOP_WAIT, STOP_HOLD, DONE.
- IDLE: on `start`, latch the shift register = {dev_addr, rw}, latch `rw` and `wr_data`, clear `ack_err`, set `busy`, pull SDA low, then go to START.
- START: count `START_HOLD` cycles, then set `sclk_en`=1 and go to ADDR with bit index 7.
- ADDR and write DATA: on `mid_low`, drive SDA = current bit (0 = pull low, 1 = release). On `end_high`, decrement the bit index. After bit 0's `end_high`, go to the ACK state.
- ADDR_ACK and write DATA_ACK: on `mid_low`, release SDA. On `mid_high`, sample SDA; a 1 sets `ack_err`. On `end_high`, go to DATA if ADDR was ACKed; otherwise go to STOP_LOW.
- Read DATA: SDA stays released. On each `mid_high`, shift SDA into `rd_data` MSB-first.
- Read DATA_ACK: on `mid_low`, release SDA (master NACK). On `end_high`, go to STOP_LOW.
- STOP_LOW: on `mid_low`, pull SDA low, then go to STOP_WAIT.
- STOP_WAIT: on the first cycle of `end_low`, set `sclk_en`=0 and `stop_cond`=1, then go to STOP_HOLD. The generator parks SCL high.
- STOP_HOLD: count `STOP_HOLD` cycles, release SDA, clear `stop_cond`, then go to DONE.
- DONE: pulse `done` for 1 cycle, clear `busy`, return to IDLE.
- `start` while `busy`=1 is ignored, and its inputs are not latched.
- Generator strobes arriving in IDLE, START, STOP_HOLD or DONE are ignored.
- `stop_cond` is never high while `sclk_en`=1.
- The generator has no reset. A `rst` asserted while SCL is low can leave SCL low, and bus recovery is handled at system level.

## Timing
- All outputs are registered. SDA changes 1 cycle after `mid_low`. The SDA sample is taken in the `mid_high` cycle.
- The START-to-`sclk_en` delay is exactly `START_HOLD`+1 cycles after the `start` cycle.
- `sclk_en` and `stop_cond` change 1 cycle after the first `end_low` cycle of the stop bit, before the generator reaches its decide step.
- The SDA rising edge occurs `STOP_HOLD` cycles after `stop_cond` rises. `done` follows 1 cycle later.
- A write transaction spans 18 SCL periods plus START and STOP. A transaction with an address NACK spans 9 SCL periods plus START and STOP.

## Test plan
- Write 0x50/0xA5, slave ACKs both bytes → SDA bits 1010000 0 (ack 0) 10100101 (ack 0); `ack_err`=0; `done` pulses once; SDA ends high.
- Read 0x50, slave returns 0x3C → address byte 0xA1; `rd_data`=0x3C at `done`; master leaves SDA high in the 9th bit; STOP follows.
- Address NACK (SDA high at the ack `mid_high`) → `ack_err`=1; no data bits clocked; STOP follows; `done` pulses.
- Write with data NACK → `ack_err`=1 after the 18th bit; STOP follows.
- `start` pulsed again mid-ADDR with `dev_addr`=0x7F → ignored; transaction completes with the original address.
- `rst` in bit 3 of DATA → next cycle `sclk_en`=0, SDA released, `busy`=0, `rd_data`=0x00.
